// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the TX response scheduler: FSM state encoding
// and the source identifiers used by the arbiter and the datapath.
package tx_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SEND  = ST_SEND,
    DRAIN = ST_DRAIN
  } state_e;

  localparam logic SRC_RD  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

endpackage

// File: rtl/tx_resp_scheduler_if.sv
// Request/response bundle between the scheduler, its two data sources and UART_TX.
// master = scheduler side, slave = surrounding datapath and transmitter.
interface tx_resp_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_BYTES  = 2
);
  logic [DATA_WIDTH-1:0]           rd_data;
  logic                            rd_data_vld;
  logic                            rd_ack;
  logic [ALU_BYTES*DATA_WIDTH-1:0] alu_out;
  logic                            alu_out_vld;
  logic                            alu_ack;
  logic                            tx_busy;
  logic [DATA_WIDTH-1:0]           tx_p_data;
  logic                            tx_d_vld;
  logic                            sched_busy;
  logic                            err_timeout;

  modport master (
    input  rd_data, rd_data_vld, alu_out, alu_out_vld, tx_busy,
    output rd_ack, alu_ack, tx_p_data, tx_d_vld, sched_busy, err_timeout
  );

  modport slave (
    output rd_data, rd_data_vld, alu_out, alu_out_vld, tx_busy,
    input  rd_ack, alu_ack, tx_p_data, tx_d_vld, sched_busy, err_timeout
  );
endinterface

// File: rtl/tx_sched_arb.sv
// Two-requester grant logic. Fixed priority (rd first) by default; defining
// TX_SCHED_RR_EN adds a round-robin pointer that moves after every finished frame.
module tx_sched_arb
  import tx_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req_rd,
  input  logic req_alu,
  input  logic frame_done,
  input  logic done_src,
  output logic gnt_vld,
  output logic gnt_src
);

`ifdef TX_SCHED_RR_EN
  logic ptr_q, ptr_d;

  // The pointer names the source that wins the next tie: the one not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (frame_done) ptr_d = ~done_src;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= SRC_RD;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_vld = req_rd | req_alu;
    if (req_rd && req_alu) gnt_src = ptr_q;
    else                   gnt_src = req_alu ? SRC_ALU : SRC_RD;
  end
`else
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{CLK, RST, frame_done, done_src};

  always_comb begin
    gnt_vld = req_rd | req_alu;
    gnt_src = req_rd ? SRC_RD : (req_alu ? SRC_ALU : SRC_RD);
  end
`endif

endmodule

// File: rtl/tx_resp_scheduler.sv
// Sequences reg-read (1 byte) and ALU (ALU_BYTES bytes, LS first) responses onto UART_TX.
// Build option TX_SCHED_RR_EN selects round-robin arbitration instead of rd-first priority.
module tx_resp_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_BYTES  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  tx_resp_scheduler_if.master  bus
);

  localparam int IDX_W = (ALU_BYTES > 1) ? $clog2(ALU_BYTES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  state_e                               state_q, state_d;
  logic                                 grant_src_q, grant_src_d;
  logic [IDX_W-1:0]                     byte_idx_q, byte_idx_d, nxt_idx;
  logic [TMO_W-1:0]                     tmo_cnt_q, tmo_cnt_d;
  logic                                 rd_pend_q, rd_pend_d;
  logic                                 alu_pend_q, alu_pend_d;
  logic [DATA_WIDTH-1:0]                rd_hold_q, rd_hold_d;
  logic [ALU_BYTES-1:0][DATA_WIDTH-1:0] alu_hold_q, alu_hold_d;
  logic                                 rd_ack_q, rd_ack_d;
  logic                                 alu_ack_q, alu_ack_d;
  logic [DATA_WIDTH-1:0]                tx_p_data_q, tx_p_data_d;
  logic                                 tx_d_vld_q, tx_d_vld_d;
  logic                                 err_timeout_q, err_timeout_d;
  logic                                 sched_busy_q, sched_busy_d;
  logic                                 rd_clr, alu_clr, frame_done;
  logic                                 gnt_vld, gnt_src;

  tx_sched_arb u_arb (
    .CLK        (CLK),
    .RST        (RST),
    .req_rd     (rd_pend_q),
    .req_alu    (alu_pend_q),
    .frame_done (frame_done),
    .done_src   (grant_src_q),
    .gnt_vld    (gnt_vld),
    .gnt_src    (gnt_src)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    grant_src_d   = grant_src_q;
    byte_idx_d    = byte_idx_q;
    tmo_cnt_d     = tmo_cnt_q;
    rd_pend_d     = rd_pend_q;
    alu_pend_d    = alu_pend_q;
    rd_hold_d     = rd_hold_q;
    alu_hold_d    = alu_hold_q;
    tx_p_data_d   = tx_p_data_q;
    tx_d_vld_d    = tx_d_vld_q;
    rd_ack_d      = 1'b0;
    alu_ack_d     = 1'b0;
    err_timeout_d = 1'b0;
    rd_clr        = 1'b0;
    alu_clr       = 1'b0;
    frame_done    = 1'b0;
    nxt_idx       = byte_idx_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (gnt_vld && !bus.tx_busy) begin
          grant_src_d = gnt_src;
          byte_idx_d  = '0;
          tmo_cnt_d   = '0;
          tx_p_data_d = (gnt_src == SRC_RD) ? rd_hold_q : alu_hold_q[0];
          tx_d_vld_d  = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (bus.tx_busy) begin
          tmo_cnt_d  = '0;
          tx_d_vld_d = 1'b0;
          state_d    = DRAIN;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          // Transmitter never accepted the byte: drop the rest of the frame.
          err_timeout_d = 1'b1;
          tmo_cnt_d     = '0;
          tx_d_vld_d    = 1'b0;
          rd_clr        = (grant_src_q == SRC_RD);
          alu_clr       = (grant_src_q == SRC_ALU);
          frame_done    = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      DRAIN: begin
        if (!bus.tx_busy) begin
          if (grant_src_q == SRC_ALU && int'(byte_idx_q) < ALU_BYTES - 1) begin
            byte_idx_d  = nxt_idx;
            tx_p_data_d = alu_hold_q[nxt_idx];
            tx_d_vld_d  = 1'b1;
            state_d     = SEND;
          end else begin
            rd_clr     = (grant_src_q == SRC_RD);
            alu_clr    = (grant_src_q == SRC_ALU);
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A cleared buffer only re-captures on the following cycle, since pending_q is still set now.
    if (rd_clr) begin
      rd_pend_d = 1'b0;
    end else if (bus.rd_data_vld && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_hold_d = bus.rd_data;
      rd_ack_d  = 1'b1;
    end

    if (alu_clr) begin
      alu_pend_d = 1'b0;
    end else if (bus.alu_out_vld && !alu_pend_q) begin
      alu_pend_d = 1'b1;
      alu_hold_d = bus.alu_out;
      alu_ack_d  = 1'b1;
    end

    sched_busy_d = (state_d != IDLE) || rd_pend_d || alu_pend_d;
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (RST) begin
      // NOTE: the holding registers are reset too; they are tiny and must read as zero after reset.
      state_q       <= IDLE;
      grant_src_q   <= SRC_RD;
      byte_idx_q    <= '0;
      tmo_cnt_q     <= '0;
      rd_pend_q     <= 1'b0;
      alu_pend_q    <= 1'b0;
      rd_hold_q     <= '0;
      alu_hold_q    <= '0;
      rd_ack_q      <= 1'b0;
      alu_ack_q     <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      sched_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_src_q   <= grant_src_d;
      byte_idx_q    <= byte_idx_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rd_pend_q     <= rd_pend_d;
      alu_pend_q    <= alu_pend_d;
      rd_hold_q     <= rd_hold_d;
      alu_hold_q    <= alu_hold_d;
      rd_ack_q      <= rd_ack_d;
      alu_ack_q     <= alu_ack_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      err_timeout_q <= err_timeout_d;
      sched_busy_q  <= sched_busy_d;
    end
  end

  assign bus.rd_ack      = rd_ack_q;
  assign bus.alu_ack     = alu_ack_q;
  assign bus.tx_p_data   = tx_p_data_q;
  assign bus.tx_d_vld    = tx_d_vld_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.sched_busy  = sched_busy_q;

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Randomized scoreboard bench for tx_resp_scheduler; honours TX_SCHED_RR_EN when defined.
module tb_tx_resp_scheduler;

  localparam int DW       = 8;
  localparam int AB       = 2;
  localparam int TMO      = 4;
  localparam int BOUND    = 200;
  localparam int N_PHASES = 40;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  tx_resp_scheduler_if #(.DATA_WIDTH(DW), .ALU_BYTES(AB)) bus ();

  tx_resp_scheduler #(.DATA_WIDTH(DW), .ALU_BYTES(AB), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct { bit drop; logic [DW-1:0] data; } ev_t;
  typedef struct { bit stall; int dly; int hold; } plan_t;

  ev_t   exp_q[$];
  plan_t plan_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit resp_en  = 1'b0;
  int rr_next  = 0;
  int last_end_cyc   = 0;
  int first_pres_cyc = -1;
  int rd_ack_cyc     = 0;
  int alu_ack_cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is a list of bytes (rd: one, alu: LS byte first); a
  // stalled byte is presented, then the frame is dropped with a timeout event.
  function automatic void serve(input int src, input logic [AB*DW-1:0] val);
    int nb       = (src == 0) ? 1 : AB;
    int stall_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
    ev_t   ev;
    plan_t p;
    for (int j = 0; j < nb; j++) begin
      ev.drop = 1'b0;
      ev.data = DW'(val >> (j * DW));
      exp_q.push_back(ev);
      p.stall = (j == stall_at);
      p.dly   = int'($urandom_range(0, 2));
      p.hold  = int'($urandom_range(1, 3));
      plan_q.push_back(p);
      if (j == stall_at) begin
        ev.drop = 1'b1;
        ev.data = '0;
        exp_q.push_back(ev);
        break;
      end
    end
    rr_next = 1 - src;
  endfunction

  task automatic drive_rd(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit got;
    for (int i = 0; i < n; i++) begin
      bus.rd_data     = (i == 0) ? a : b;
      bus.rd_data_vld = 1'b1;
      got = 1'b0;
      for (int t = 0; t < BOUND; t++) begin
        @(negedge CLK);
        if (bus.rd_ack) begin got = 1'b1; break; end
      end
      check("rd_ack_seen", 32'(got), 32'd1);
      if (i == 0) rd_ack_cyc = cyc;
      else        check("bp_ack_cycle", 32'(cyc), 32'(last_end_cyc + 1));
    end
    bus.rd_data_vld = 1'b0;
  endtask

  task automatic drive_alu(input logic [AB*DW-1:0] v);
    bit got = 1'b0;
    bus.alu_out     = v;
    bus.alu_out_vld = 1'b1;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge CLK);
      if (bus.alu_ack) begin got = 1'b1; break; end
    end
    check("alu_ack_seen", 32'(got), 32'd1);
    alu_ack_cyc     = cyc;
    bus.alu_out_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge CLK);
      if (!bus.sched_busy && !bus.tx_busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  // UART_TX stand-in: acts on each new byte according to the next plan entry.
  initial begin
    plan_t p;
    int    n;
    bit    got;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (resp_en && bus.tx_d_vld) begin
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else                    p = '{stall: 1'b0, dly: 2, hold: 2};
        if (p.stall) begin
          n = 0; got = 1'b0;
          for (int t = 0; t < BOUND; t++) begin
            @(negedge CLK);
            n++;
            if (bus.err_timeout) begin got = 1'b1; break; end
          end
          check("tmo_seen", 32'(got), 32'd1);
          check("tmo_cycles", 32'(n), 32'(TMO));
          check("tmo_vld_low", 32'(bus.tx_d_vld), 32'd0);
          last_end_cyc = cyc;
        end else begin
          repeat (p.dly) @(negedge CLK);
          bus.tx_busy = 1'b1;
          @(negedge CLK);
          check("vld_fall", 32'(bus.tx_d_vld), 32'd0);
          repeat (p.hold - 1) @(negedge CLK);
          bus.tx_busy  = 1'b0;
          last_end_cyc = cyc + 1;
        end
      end
    end
  end

  // Monitor: every new byte presentation and every timeout pulse pops one expected event.
  initial begin
    bit  prev_vld = 1'b0;
    ev_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (bus.tx_d_vld && !prev_vld) begin
          if (first_pres_cyc < 0) first_pres_cyc = cyc;
          check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_byte", {23'd0, 1'b0, bus.tx_p_data}, {23'd0, e.drop, e.data});
          end
        end
        if (bus.err_timeout) begin
          check("drop_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("drop_evt", 32'(bus.err_timeout), 32'(e.drop));
          end
        end
      end
      prev_vld = bus.tx_d_vld;
    end
  end

  initial begin
    int               kind;
    logic [DW-1:0]    ra, rb;
    logic [AB*DW-1:0] av;
    bit               got;

    bus.rd_data = '0; bus.rd_data_vld = 1'b0;
    bus.alu_out = '0; bus.alu_out_vld = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_tx_d_vld",   32'(bus.tx_d_vld),    32'd0);
    check("rst_sched_busy", 32'(bus.sched_busy),  32'd0);
    check("rst_rd_ack",     32'(bus.rd_ack),      32'd0);
    check("rst_alu_ack",    32'(bus.alu_ack),     32'd0);
    check("rst_err",        32'(bus.err_timeout), 32'd0);
    check("rst_tx_data",    32'(bus.tx_p_data),   32'd0);
    RST = 1'b0;

    // Reset while SEND is active, with rd_data_vld still held by the source.
    bus.rd_data = 8'hA5; bus.rd_data_vld = 1'b1;
    got = 1'b0;
    for (int t = 0; t < BOUND; t++) begin
      @(negedge CLK);
      if (bus.tx_d_vld) begin got = 1'b1; break; end
    end
    check("pre_rst_vld",  32'(got),           32'd1);
    check("pre_rst_data", 32'(bus.tx_p_data), 32'hA5);
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("in_rst_vld",  32'(bus.tx_d_vld),   32'd0);
      check("in_rst_busy", 32'(bus.sched_busy), 32'd0);
      check("in_rst_ack",  32'(bus.rd_ack),     32'd0);
    end
    resp_en = 1'b1;
    RST     = 1'b0;
    @(negedge CLK);
    check("recapture_ack", 32'(bus.rd_ack), 32'd1);
    bus.rd_data_vld = 1'b0;
    @(negedge CLK);
    check("recapture_vld",  32'(bus.tx_d_vld),  32'd1);
    check("recapture_data", 32'(bus.tx_p_data), 32'hA5);
    wait_idle();
    rr_next = 1;  // the completed rd frame leaves the round-robin pointer on alu
    mon_en  = 1'b1;

    for (int ph = 0; ph < N_PHASES; ph++) begin
      kind = (ph < 4) ? ph : int'($urandom_range(0, 3));
      ra = DW'($urandom); rb = DW'($urandom); av = (AB*DW)'($urandom);
      if (ph == 1) av = 16'h1234;
      if (ph == 2) begin ra = 8'hA5; av = 16'h1234; end
      first_pres_cyc = -1;
      case (kind)
        0: serve(0, {8'd0, ra});
        1: serve(1, av);
        2: begin
`ifdef TX_SCHED_RR_EN
          if (rr_next == 1) begin serve(1, av); serve(0, {8'd0, ra}); end
          else              begin serve(0, {8'd0, ra}); serve(1, av); end
`else
          serve(0, {8'd0, ra}); serve(1, av);
`endif
        end
        default: begin serve(0, {8'd0, ra}); serve(0, {8'd0, rb}); end
      endcase
      @(negedge CLK);
      fork
        begin
          if (kind == 0 || kind == 2) drive_rd(1, ra, rb);
          else if (kind == 3)         drive_rd(2, ra, rb);
        end
        begin
          if (kind == 1 || kind == 2) drive_alu(av);
        end
      join
      wait_idle();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      if (kind == 0) check("ack_to_vld_latency", 32'(first_pres_cyc - rd_ack_cyc), 32'd1);
      if (kind == 2) check("dual_ack_same_cycle", 32'(rd_ack_cyc), 32'(alu_ack_cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
